// File: rtl/video_stream_ctrl_pkg.sv
// StarSoC shared video parameters, plus the stream controller state type and
// the 4-bit-per-channel to 8-bit-per-channel colour expansion helper.
package starsoc_params;
  localparam int H_VISIBLE        = 640;
  localparam int V_VISIBLE        = 480;
  localparam int VISIBLE_ORIGIN_X = 0;
  localparam int VISIBLE_ORIGIN_Y = 0;

  // FIFO beat layout: {tdata[23:0], tuser, tlast}
  localparam int BEAT_W = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    RESYNC = 2'd3
  } stream_state_t;

  function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction
endpackage

// File: rtl/video_stream_ctrl_if.sv
// AXI4-Stream video beat bus between the stream controller and the video sink.
interface video_stream_ctrl_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_stream_ctrl_axis_beat_fifo.sv
// First-word-fall-through beat FIFO; a write into a full FIFO is accepted only
// when the head is popped on the same edge.
module axis_beat_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 26,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_level == '0);
  assign o_full  = (o_level == LVL_FULL);
  assign w_do_rd = i_rd_en && !o_empty;
  assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

  // Head reads as zero when empty so the bus shows clean data after reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/video_stream_ctrl.sv
// Packs visible pixels from the free-running timing source into AXI4-Stream
// video beats, buffering backpressure and dropping to the next frame on overflow.
module video_stream_ctrl #(
  parameter int H_VISIBLE  = starsoc_params::H_VISIBLE,
  parameter int V_VISIBLE  = starsoc_params::V_VISIBLE,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        pixel_clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        video_on,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [11:0]                 rgb_in,
  video_stream_ctrl_if.master         m_axis,
  output logic                        frame_active,
  output logic                        overflow_sticky,
  input  logic                        clear_overflow,
  output logic [CNT_W-1:0]            drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  import starsoc_params::*;

  stream_state_t     r_state;
  logic              r_sticky;
  logic [CNT_W-1:0]  r_drop;

  logic              w_sof;
  logic              w_eol;
  logic              w_eof;
  logic              w_pop;
  logic              w_wr_req;
  logic              w_ovf;
  logic              w_wr;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [BEAT_W-1:0] w_head;

  assign w_sof = video_on && (pixel_x == '0) && (pixel_y == '0);
  assign w_eol = video_on && (pixel_x == 10'(H_VISIBLE-1));
  assign w_eof = w_eol && (pixel_y == 10'(V_VISIBLE-1));
  assign w_pop = !w_empty && m_axis.tready;

  always_comb begin
    w_wr_req = 1'b0;
    unique case (r_state)
      ARMED:   w_wr_req = enable && w_sof;
      STREAM:  w_wr_req = video_on;
      RESYNC:  w_wr_req = enable && w_sof;
      default: w_wr_req = 1'b0;
    endcase
  end

  // A pop on the same edge frees the slot, so a full FIFO only overflows without one.
  assign w_ovf  = w_wr_req && w_full && !w_pop;
  assign w_wr   = w_wr_req && !w_ovf;
  assign w_drop = w_ovf || ((r_state == RESYNC) && video_on && !w_sof);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_sticky <= 1'b0;
      r_drop   <= '0;
    end else begin
      unique case (r_state)
        IDLE:    if (enable) r_state <= ARMED;
        ARMED:   if (!enable) r_state <= IDLE;
                 else if (w_sof) r_state <= STREAM;
        STREAM:  if (w_eof && !enable) r_state <= IDLE;
        RESYNC:  if (w_sof) r_state <= enable ? STREAM : IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_ovf) r_state <= RESYNC;

      if (clear_overflow) begin
        r_sticky <= 1'b0;
        r_drop   <= '0;
      end else if (w_drop) begin
        r_sticky <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  axis_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_wr),
    .i_wr_data ({rgb444_to_888(rgb_in), w_sof, w_eol}),
    .i_rd_en   (m_axis.tready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  assign m_axis.tvalid = !w_empty;
  assign m_axis.tdata  = w_head[25:2];
  assign m_axis.tuser  = w_head[1];
  assign m_axis.tlast  = w_head[0];

  assign frame_active    = (r_state == STREAM);
  assign overflow_sticky = r_sticky;
  assign drop_count      = r_drop;
endmodule

// File: tb/tb_video_stream_ctrl.sv
// Randomised bench for video_stream_ctrl on a reduced raster, checked every cycle
// against a queue-based frame/backpressure model plus literal scenario checks.
module tb_video_stream_ctrl;
  localparam int H    = 16;
  localparam int V    = 8;
  localparam int HT   = 20;
  localparam int VT   = 10;
  localparam int D    = 8;
  localparam int CW   = 8;
  localparam int LW   = $clog2(D) + 1;
  localparam int MAXC = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_ARMED = 1, M_STREAM = 2, M_RESYNC = 3;

  logic          pixel_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          video_on = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [9:0]    pixel_x = '0;
  logic [9:0]    pixel_y = '0;
  logic [11:0]   rgb_in = '0;
  logic          frame_active;
  logic          overflow_sticky;
  logic [CW-1:0] drop_count;
  logic [LW-1:0] fifo_level;

  video_stream_ctrl_if m_axis();

  video_stream_ctrl #(
    .H_VISIBLE (H), .V_VISIBLE (V), .FIFO_DEPTH (D), .CNT_W (CW)
  ) dut (
    .pixel_clk       (pixel_clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .video_on        (video_on),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .rgb_in          (rgb_in),
    .m_axis          (m_axis),
    .frame_active    (frame_active),
    .overflow_sticky (overflow_sticky),
    .clear_overflow  (clear_overflow),
    .drop_count      (drop_count),
    .fifo_level      (fifo_level)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp888(input logic [11:0] c);
    int r, g, b;
    r = int'(c[11:8]);
    g = int'(c[7:4]);
    b = int'(c[3:0]);
    return 24'((r * 17) * 65536 + (g * 17) * 256 + b * 17);
  endfunction

  // ---------------- behavioural model ----------------
  logic [25:0] mq[$];
  int          m_mode = M_IDLE;
  int          m_drop = 0;
  bit          m_sticky = 0;

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE;
    m_drop = 0;
    m_sticky = 0;
  endtask

  task automatic model_step();
    bit sof, eol, eof, pop, want, ovf, dropped;
    int nmode;
    sof = video_on && pixel_x == 0 && pixel_y == 0;
    eol = video_on && pixel_x == H - 1;
    eof = eol && pixel_y == V - 1;
    pop = (mq.size() != 0) && m_axis.tready;
    want = 0;
    dropped = 0;
    nmode = m_mode;
    case (m_mode)
      M_IDLE:   if (enable) nmode = M_ARMED;
      M_ARMED:  if (!enable) nmode = M_IDLE;
                else if (sof) begin want = 1; nmode = M_STREAM; end
      M_STREAM: begin
                  want = video_on;
                  if (eof && !enable) nmode = M_IDLE;
                end
      default:  if (sof) begin
                  if (enable) begin want = 1; nmode = M_STREAM; end
                  else nmode = M_IDLE;
                end else if (video_on) dropped = 1;
    endcase
    ovf = want && (mq.size() == D) && !pop;
    if (ovf) begin
      nmode = M_RESYNC;
      dropped = 1;
    end
    if (pop) void'(mq.pop_front());
    if (want && !ovf) mq.push_back({exp888(rgb_in), sof, eol});
    if (clear_overflow) begin
      m_sticky = 0;
      m_drop = 0;
    end else if (dropped) begin
      m_sticky = 1;
      if (m_drop < MAXC) m_drop++;
    end
    m_mode = nmode;
  endtask

  // ---------------- per-cycle compare + beat monitor ----------------
  int beats = 0, tuser_cnt = 0, tlast_cnt = 0;
  bit first_user = 0, last_tlast = 0;

  initial begin
    forever begin
      @(posedge pixel_clk);
      if (!reset_n) model_reset();
      else model_step();
      #3;
      if (reset_n) begin
        chk("tvalid", m_axis.tvalid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("tdata", m_axis.tdata, mq[0][25:2]);
          chk("tuser", m_axis.tuser, mq[0][1]);
          chk("tlast", m_axis.tlast, mq[0][0]);
        end
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow_sticky", overflow_sticky, m_sticky);
        chk("drop_count", drop_count, m_drop);
        chk("frame_active", frame_active, m_mode == M_STREAM);
        if (m_axis.tvalid && m_axis.tready) begin
          if (beats == 0) first_user = m_axis.tuser;
          beats++;
          tuser_cnt += int'(m_axis.tuser);
          tlast_cnt += int'(m_axis.tlast);
          last_tlast = m_axis.tlast;
        end
      end
    end
  end

  // ---------------- timing source / stimulus ----------------
  int          hc = HT - 1;
  int          vc = V;
  int          ready_mode = 0;
  bit          force_en = 0;
  logic [11:0] force_val = '0;
  bit          cap_on = 0;
  logic [11:0] cap[$];

  task automatic tick();
    @(posedge pixel_clk);
    #2;
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc++;
      if (vc == VT) vc = 0;
    end
    pixel_x  = 10'(hc);
    pixel_y  = 10'(vc);
    video_on = (hc < H) && (vc < V);
    rgb_in   = (force_en && hc == 0 && vc == 0) ? force_val : 12'($urandom);
    if (cap_on && video_on) cap.push_back(rgb_in);
    case (ready_mode)
      0:       m_axis.tready = 1'b1;
      1:       m_axis.tready = 1'b0;
      default: m_axis.tready = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  task automatic run_to(input int x, input int y);
    for (int n = 0; n < 2 * HT * VT; n++) begin
      tick();
      if (hc == x && vc == y) break;
    end
  endtask

  task automatic colour_check(input logic [11:0] c, input logic [23:0] want);
    force_en = 1;
    force_val = c;
    run_to(0, 0);
    tick();
    #1;
    chk("colour_tvalid", m_axis.tvalid, 1);
    chk("colour_tdata", m_axis.tdata, want);
    chk("colour_tuser", m_axis.tuser, 1);
    force_en = 0;
  endtask

  initial begin
    m_axis.tready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_tuser", m_axis.tuser, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_sticky", overflow_sticky, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_active", frame_active, 0);
    tick();
    reset_n = 1;
    enable = 1;

    // one full frame, no backpressure
    beats = 0; tuser_cnt = 0; tlast_cnt = 0;
    run_to(0, 0);
    run_to(0, V);
    chk("frame_beats", beats, H * V);
    chk("frame_first_tuser", first_user, 1);
    chk("frame_tuser_cnt", tuser_cnt, 1);
    chk("frame_tlast_cnt", tlast_cnt, V);
    chk("frame_drop", drop_count, 0);

    // colour expansion
    colour_check(12'hF80, 24'hFF8800);
    colour_check(12'h000, 24'h000000);
    colour_check(12'hFFF, 24'hFFFFFF);

    // full FIFO with a pop on the write edge
    run_to(HT - 1, VT - 1);
    ready_mode = 1;
    run_to(7, 0);
    ready_mode = 0;
    tick();
    #1;
    chk("full_level", fifo_level, D);
    tick();
    #1;
    chk("full_pop_level", fifo_level, D);
    chk("full_pop_sticky", overflow_sticky, 0);
    run_to(0, V);

    // overflow and resync
    run_to(HT - 1, VT - 1);
    ready_mode = 1;
    cap.delete();
    cap_on = 1;
    run_to(7, 0);
    cap_on = 0;
    tick();
    #1;
    chk("ovf_level", fifo_level, D);
    chk("ovf_sticky_before", overflow_sticky, 0);
    tick();
    #1;
    chk("ovf_sticky", overflow_sticky, 1);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_active", frame_active, 0);
    chk("ovf_level_kept", fifo_level, D);
    run_to(H - 1, V - 1);
    tick();
    #1;
    chk("ovf_frame_drop", drop_count, H * V - D);
    run_to(0, V + 1);
    ready_mode = 0;
    for (int i = 0; i < D; i++) begin
      tick();
      #1;
      chk("drain_tvalid", m_axis.tvalid, 1);
      chk("drain_tdata", m_axis.tdata, exp888(cap[i]));
      chk("drain_tuser", m_axis.tuser, i == 0);
    end
    run_to(0, 0);
    tick();
    #1;
    chk("resync_tvalid", m_axis.tvalid, 1);
    chk("resync_tuser", m_axis.tuser, 1);
    chk("resync_active", frame_active, 1);

    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    #1;
    chk("clear_sticky", overflow_sticky, 0);
    chk("clear_drop", drop_count, 0);

    // drop counter saturation, then clear beating a same-edge increment
    run_to(0, V);
    ready_mode = 1;
    run_to(0, 0);
    run_to(0, 0);
    run_to(0, 0);
    run_to(0, V);
    chk("sat_drop", drop_count, MAXC);
    chk("sat_sticky", overflow_sticky, 1);
    run_to(0, 0);
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    #1;
    chk("clrprio_sticky", overflow_sticky, 0);
    chk("clrprio_drop", drop_count, 0);
    tick();
    #1;
    chk("resync_drop_inc", drop_count, 1);

    // enable dropped mid-frame
    ready_mode = 0;
    run_to(0, V);
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    run_to(HT - 1, VT - 1);
    beats = 0; tlast_cnt = 0; last_tlast = 0;
    run_to(5, 3);
    enable = 0;
    run_to(0, V + 1);
    chk("en_off_beats", beats, H * V);
    chk("en_off_tlast_cnt", tlast_cnt, V);
    chk("en_off_last_tlast", last_tlast, 1);
    chk("en_off_active", frame_active, 0);
    beats = 0;
    run_to(0, V + 1);
    chk("en_off_next_beats", beats, 0);

    // async reset mid-line
    enable = 1;
    ready_mode = 1;
    run_to(4, 2);
    tick();
    #1;
    chk("prereset_tvalid", m_axis.tvalid, 1);
    tick();
    reset_n = 0;
    #1;
    chk("async_tvalid", m_axis.tvalid, 0);
    chk("async_level", fifo_level, 0);
    chk("async_sticky", overflow_sticky, 0);
    ready_mode = 0;
    tick();
    tick();
    reset_n = 1;
    beats = 0;
    run_to(0, 0);
    chk("postreset_no_partial", beats, 0);
    tick();
    #1;
    chk("postreset_tvalid", m_axis.tvalid, 1);
    chk("postreset_tuser", m_axis.tuser, 1);

    // randomised frames
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      run_to(0, V + 1);
      enable = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < HT * VT; k++) begin
        tick();
        clear_overflow = ($urandom_range(0, 63) == 0);
      end
      clear_overflow = 0;
    end
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
